// File: rtl/eth_frame_tx_pkg.sv
// Shared FSM encoding, frame-shaping limits and small helpers for the
// Ethernet TX frame generator.
package eth_frame_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_GAP
    } tx_state_t;

    localparam logic [15:0] MIN_FRAME_LEN = 16'd60;
    localparam logic [15:0] MIN_IFG       = 16'd12;
    localparam logic [30:0] PRBS_SEED     = 31'h7FFF_FFFF;

    function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_frame_tx_hdr_ram.sv
// Header template store: one write port, one enabled synchronous read port.
// A read and write to the same address in one cycle returns the old byte.
module eth_frame_tx_hdr_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/eth_frame_tx_engine.sv
// Ethernet frame generator feeding a TEMAC 8-bit AXI4-Stream TX port: header
// template + generated payload + inter-frame gap. Define ETH_FRAME_TX_PRBS_EN
// to replace the incrementing payload with a PRBS-31 pattern.
module eth_frame_tx_engine
    import eth_frame_tx_pkg::*;
#(
    parameter int  C_HEADER_SIZE = 128,
    localparam int HW            = $clog2(C_HEADER_SIZE) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [15:0]   frame_size,
    input  logic [HW-1:0] header_size,
    input  logic [15:0]   ifg,
    input  logic [31:0]   frame_limit,
    input  logic          hdr_we,
    input  logic [HW-2:0] hdr_addr,
    input  logic [7:0]    hdr_wdata,
    input  logic [63:0]   current_time,
    output logic [7:0]    m_axis_tdata,
    output logic          m_axis_tuser,
    output logic          m_axis_tlast,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          busy,
    output logic          done,
    output logic [63:0]   frames_sent,
    output logic [63:0]   bytes_sent,
    output logic [63:0]   tx_time
);

    tx_state_t     r_state;
    tx_state_t     w_next_state;

    logic [15:0]   r_frame_len;
    logic [15:0]   r_hdr_len;
    logic [15:0]   r_gap;
    logic [15:0]   r_idx;
    logic [15:0]   r_gap_cnt;
    logic [31:0]   r_sess_cnt;
    logic          r_done;
    logic [63:0]   r_frames_sent;
    logic [63:0]   r_bytes_sent;
    logic [63:0]   r_tx_time;

    logic [15:0]   w_eff_frame;
    logic [15:0]   w_eff_hdr;
    logic [15:0]   w_eff_gap;
    logic [15:0]   w_idx_inc;
    logic          w_valid;
    logic          w_last;
    logic          w_hs;
    logic          w_last_hs;
    logic          w_limit_hit;
    logic          w_start;
    logic          w_ram_re;
    logic [HW-2:0] w_ram_raddr;
    logic [7:0]    w_ram_rdata;
    logic [7:0]    w_payload;

    assign w_eff_frame = max16(frame_size, MIN_FRAME_LEN);
    assign w_eff_hdr   = min16(min16(16'(header_size), 16'(C_HEADER_SIZE)), w_eff_frame);
    assign w_eff_gap   = max16(ifg, MIN_IFG);

    assign w_idx_inc   = r_idx + 16'd1;
    assign w_valid     = (r_state == S_HEADER) || (r_state == S_PAYLOAD);
    assign w_last      = w_valid && (r_idx == r_frame_len - 16'd1);
    assign w_hs        = w_valid && m_axis_tready;
    assign w_last_hs   = w_hs && w_last;
    assign w_start     = (r_state == S_IDLE) && enable && !r_done;
    assign w_limit_hit = w_last_hs && (frame_limit != 32'd0) &&
                         (r_sess_cnt + 32'd1 == frame_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next_state = (w_eff_hdr != 16'd0) ? S_HEADER : S_PAYLOAD;
            end
            S_HEADER: begin
                if (w_last_hs) begin
                    w_next_state = S_GAP;
                end else if (w_hs && (r_idx == r_hdr_len - 16'd1)) begin
                    w_next_state = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_last_hs) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == 16'd0) begin
                    w_next_state = (enable && !r_done) ? S_LOAD : S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Frame configuration is frozen for the whole frame once LOAD has run.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            r_frame_len <= w_eff_frame;
            r_hdr_len   <= w_eff_hdr;
            r_gap       <= w_eff_gap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx         <= '0;
            r_gap_cnt     <= '0;
            r_sess_cnt    <= '0;
            r_done        <= 1'b0;
            r_frames_sent <= '0;
            r_bytes_sent  <= '0;
            r_tx_time     <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_idx <= '0;
            end else if (w_hs) begin
                r_idx <= w_idx_inc;
            end

            // LOAD is the last idle cycle, so GAP itself lasts gap-1 cycles.
            if (w_last_hs) begin
                r_gap_cnt <= r_gap - 16'd2;
            end else if ((r_state == S_GAP) && (r_gap_cnt != 16'd0)) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end

            if (w_start) begin
                r_sess_cnt <= '0;
            end else if (w_last_hs) begin
                r_sess_cnt <= r_sess_cnt + 32'd1;
            end

            if (w_limit_hit) begin
                r_done <= 1'b1;
            end else if (!enable) begin
                r_done <= 1'b0;
            end

            if (w_hs) begin
                r_bytes_sent <= r_bytes_sent + 64'd1;
                if (r_idx == 16'd0) begin
                    r_tx_time <= current_time;
                end
            end

            if (w_last_hs) begin
                r_frames_sent <= r_frames_sent + 64'd1;
            end
        end
    end

    // Template reads advance only on handshakes so tdata holds during stalls.
    assign w_ram_re    = (r_state == S_LOAD) || ((r_state == S_HEADER) && w_hs);
    assign w_ram_raddr = (r_state == S_LOAD) ? '0 : w_idx_inc[HW-2:0];

    eth_frame_tx_hdr_ram #(
        .DEPTH (C_HEADER_SIZE),
        .AW    (HW - 1)
    ) u_hdr_ram (
        .clk     (clk),
        .i_we    (hdr_we),
        .i_waddr (hdr_addr),
        .i_wdata (hdr_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

`ifdef ETH_FRAME_TX_PRBS_EN
    logic [30:0] r_lfsr;

    function automatic logic [30:0] prbs_step8(input logic [30:0] s);
        logic [30:0] v;
        v = s;
        for (int i = 0; i < 8; i++) begin
            v = {v[29:0], v[30] ^ v[27]};
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (r_state == S_LOAD) begin
            r_lfsr <= PRBS_SEED;
        end else if (w_hs && (r_state == S_PAYLOAD)) begin
            r_lfsr <= prbs_step8(r_lfsr);
        end
    end

    assign w_payload = r_lfsr[7:0];
`else
    assign w_payload = r_idx[7:0];
`endif

    assign m_axis_tvalid = w_valid;
    assign m_axis_tlast  = w_last;
    assign m_axis_tuser  = 1'b0;
    assign m_axis_tdata  = !w_valid ? 8'h00 :
                           (r_state == S_HEADER) ? w_ram_rdata : w_payload;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done | w_limit_hit;
    assign frames_sent   = r_frames_sent;
    assign bytes_sent    = r_bytes_sent;
    assign tx_time       = r_tx_time;

endmodule

// File: doc/eth_frame_tx_engine.md
# eth_frame_tx_engine

Single-clock Ethernet frame generator that drives the 8-bit AXI4-Stream TX interface of a TEMAC, acting as the transmit-side counterpart of the frame detector's stream inputs. It emits frames built from a programmable header template followed by a generated payload, separated by a programmable inter-frame gap. It keeps 64-bit frame and byte counters and captures a transmit timestamp, all for the AXI-Lite register block in the same clock domain. The FCS is appended by the TEMAC, not by this block.

## Interface
- C_HEADER_SIZE, 128, header template depth in bytes (power of two, 16..256); HW = $clog2(C_HEADER_SIZE)+1
- clk  in  1  core clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  level; high = generate frames
- frame_size  in  16  frame length in bytes, excluding FCS
- header_size  in  HW  number of template bytes sent at frame start
- ifg  in  16  idle cycles between frames
- frame_limit  in  32  frames per enable session; 0 = unlimited
- hdr_we  in  1  template write strobe
- hdr_addr  in  HW-1  template write address
- hdr_wdata  in  8  template write byte
- current_time  in  64  free-running timer
- m_axis_tdata  out  8  frame byte
- m_axis_tuser  out  1  underrun flag; constant 0
- m_axis_tlast  out  1  last byte of frame
- m_axis_tvalid  out  1  byte valid
- m_axis_tready  in  1  TEMAC accepts byte
- busy  out  1  high in any state except IDLE
- done  out  1  frame_limit reached in this session
- frames_sent  out  64  frames completed since reset
- bytes_sent  out  64  bytes accepted since reset
- tx_time  out  64  current_time value at the first-byte handshake of the last frame

## Operation
- Reset value of every output is 0, and the FSM goes to IDLE.
- FSM states:
  - IDLE: wait for enable=1 and done=0.
  - LOAD: latch frame_size, header_size and ifg; issue the template read for address 0.
  - HEADER: stream template bytes.
  - PAYLOAD: stream generated bytes.
  - GAP: count ifg cycles.
- Transitions:
  - IDLE -> LOAD when enable=1 and done=0.
  - LOAD -> HEADER when the effective header length > 0; otherwise LOAD -> PAYLOAD.
  - HEADER -> PAYLOAD after the last header byte handshake, unless the frame has ended.
  - Final byte handshake -> GAP.
  - GAP -> LOAD when the gap has expired, enable=1 and the limit is not reached; otherwise GAP -> IDLE.
- Clamping, applied in LOAD:
  - effective frame length = max(frame_size, 60).
  - effective header length = min(header_size, C_HEADER_SIZE, effective frame length).
  - effective gap = max(ifg, 12).
- The configuration latched in LOAD holds for the whole frame. Changes to the inputs mid-frame do not take effect until the next LOAD.
- enable dropping mid-frame does not truncate the frame. The frame completes, then GAP, then IDLE.
- A session begins when enable rises while in IDLE. The session frame count clears at that point.
  - When frame_limit≠0 and the session count reaches frame_limit at the last-byte handshake, done is set in the same cycle.
  - done clears when enable=0.
- Byte index is a 16-bit counter from 0. m_axis_tlast=1 exactly when index = effective frame length−1.
- Counters:
  - bytes_sent += 1 on every handshake (tvalid & tready).
  - frames_sent += 1 on the tlast handshake.
  - Both wrap modulo 2^64.
  - tx_time is loaded on the handshake of index 0.
- Template writes are allowed at any time. A write to an address being read in the same cycle returns the old byte (read-first).

## Timing
- AXI4-Stream rules:
  - tvalid never depends on tready.
  - Once tvalid=1, tdata and tlast stay stable until the handshake.
  - Back-to-back bytes are sent when tready stays 1: one byte per cycle, no bubbles inside a frame.
- First-byte latency: enable sampled high in IDLE at cycle N gives LOAD at N+1 and tvalid=1 at N+2.
- Gap: the last handshake at cycle T gives tvalid=0 for exactly effective-gap cycles after T (GAP, plus the LOAD cycle which counts as one gap cycle). The next tvalid rises at T+gap+1.
- tready low stalls the byte index, the template read address and the payload generator. No byte is skipped or repeated.
- rst mid-frame drops tvalid on the next edge. The partial frame is abandoned and no tlast is issued; the TEMAC's frame timeout handles the truncated frame.

## Configuration
- ETH_FRAME_TX_PRBS_EN defined:
  - payload byte = low 8 bits of a PRBS-31 LFSR (x^31+x^28+1), advancing 8 steps per accepted byte.
  - The LFSR is reseeded to 31'h7FFFFFFF in LOAD.
- ETH_FRAME_TX_PRBS_EN undefined:
  - payload byte = low 8 bits of the byte index (incrementing pattern).
  - No LFSR logic is synthesised.

## Structure
- Package eth_frame_tx_pkg: the state enum, MIN_FRAME_LEN=60, MIN_IFG=12, PRBS_SEED.
- Sub-module eth_frame_tx_hdr_ram: simple dual-port template RAM, with a 1-cycle synchronous read and read-first behaviour.

## Test plan
- **Minimal frame:** frame_size=60, header_size=14 with template 0x00..0x0D, ifg=12, tready=1, PRBS off → bytes 0x00..0x0D then 0x0E..0x3B; tlast on byte 60; next tvalid 13 cycles after the last handshake.
- **Clamping:** frame_size=10, header_size=200, ifg=0 with C_HEADER_SIZE=128 → 60-byte frames, header truncated to 60 bytes, gap of 12 cycles.
- **Backpressure:** tready toggles pseudo-randomly over a 100-byte frame → exactly 100 handshakes; tdata sequence identical to the tready=1 run; bytes_sent=100.
- **Limit:** frame_limit=3 with enable held high → 3 frames; done=1 in the third frame's tlast cycle; frames_sent=3; no fourth tvalid. Dropping then raising enable → 3 more frames.
- **Enable drop mid-frame:** enable=0 at byte 20 of a 64-byte frame → the frame completes with tlast; busy falls after the gap.
- **Reset mid-frame:** rst at byte 30 → the next cycle has tvalid=0, all counters 0, FSM in IDLE; the next session starts cleanly at template byte 0.
